neuron_seq: RTL and testbench

Sequential, handshaked successor to the combinational FP16 neuron. Consumes one IEEE 754 half-precision input/weight pair per accepted beat over a vector of N beats. Adds the products to the bias and applies a run-time-selectable activation (identity, ReLU, ReLU6, leaky ReLU). Sits between the layer's operand streamer and the activation writeback buffer, and is the building block replicated per output neuron in the pipelined layer.

---
 rtl/neuron_pkg.sv | 33 +++
 rtl/neuron_seq_fp16_mac.sv | 86 ++++++++
 rtl/neuron_seq.sv | 114 +++++++++++
 tb/tb_neuron_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared FP16 constants, activation/state enums and an operand
// sanitizer used by the sequential neuron and its MAC datapath.
package neuron_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_SIX  = 16'h4600;
    localparam logic [15:0] FP16_MAX  = 16'h7BFF;

    typedef enum logic [1:0] {
        ACT_ID    = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_RELU6 = 2'b10,
        ACT_LEAKY = 2'b11
    } act_mode_t;

    typedef enum logic [1:0] {
        S_ACC = 2'b00,
        S_ACT = 2'b01,
        S_OUT = 2'b10
    } state_t;

    // Subnormals (and -0) become +0; Inf/NaN become max finite of the same sign.
    function automatic logic [15:0] fp16_sanitize(input logic [15:0] v);
        if (v[14:10] == '0) return FP16_ZERO;
        if (v[14:10] == '1) return {v[15], FP16_MAX[14:0]};
        return v;
    endfunction

endpackage

// File: rtl/neuron_seq_fp16_mac.sv
// fp16_mac: combinational y = a + x*w in FP16.
// Product rounded to FP16 first, then the sum; both truncate toward zero.
// Subnormal results flush to +0, overflow saturates to +/-max finite.
// Ports:
//   a [16] in  addend (bias or running accumulator)
//   x [16] in  input activation
//   w [16] in  weight
//   y [16] out rounded result
module fp16_mac
    import neuron_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] x,
    input  logic [15:0] w,
    output logic [15:0] y
);

    // Exact value of a normal FP16 in units of 2^-24 (exponent 30 needs 40 bits).
    function automatic logic [40:0] to_fixed(input logic [14:0] v);
        if (v[14:10] == '0) return '0;
        return 41'({1'b1, v[9:0]}) << (v[14:10] - 5'd1);
    endfunction

    logic [15:0]       a_s, x_s, w_s;
    logic [21:0]       p_sig;
    logic signed [7:0] p_exp;
    logic [9:0]        p_man;
    logic              p_sign;
    logic [15:0]       p;

    logic [40:0] a_fx, p_fx, mag;
    logic        a_big, r_sign;
    logic [5:0]  lead;
    logic [9:0]  r_man;

    assign a_s = fp16_sanitize(a);
    assign x_s = fp16_sanitize(x);
    assign w_s = fp16_sanitize(w);

    always_comb begin
        p_sign = x_s[15] ^ w_s[15];
        p_sig  = {11'd0, 1'b1, x_s[9:0]} * {11'd0, 1'b1, w_s[9:0]};
        p_exp  = $signed({3'b000, x_s[14:10]}) + $signed({3'b000, w_s[14:10]}) - 8'sd15;
        p_man  = 10'(p_sig >> 10);
        if (p_sig[21]) begin
            p_exp = p_exp + 8'sd1;
            p_man = 10'(p_sig >> 11);
        end
        if (x_s[14:10] == '0 || w_s[14:10] == '0 || p_exp < 8'sd1)
            p = FP16_ZERO;
        else if (p_exp > 8'sd30)
            p = {p_sign, FP16_MAX[14:0]};
        else
            p = {p_sign, p_exp[4:0], p_man};
    end

    // The sum is formed exactly in fixed point and only then truncated, so
    // subtraction never rounds away from zero.
    always_comb begin
        a_fx  = to_fixed(a_s[14:0]);
        p_fx  = to_fixed(p[14:0]);
        a_big = (a_fx >= p_fx);
        if (a_s[15] == p[15])
            mag = a_fx + p_fx;
        else if (a_big)
            mag = a_fx - p_fx;
        else
            mag = p_fx - a_fx;
        r_sign = a_big ? a_s[15] : p[15];

        lead = '0;
        for (int i = 0; i < 41; i++)
            if (mag[i]) lead = 6'(i);

        r_man = 10'(mag >> (lead - 6'd10));

        // Leading one below bit 10 is subnormal or exact zero: both give +0.
        if (lead < 6'd10)
            y = FP16_ZERO;
        else if (lead >= 6'd40)
            y = {r_sign, FP16_MAX[14:0]};
        else
            y = {r_sign, 5'(lead - 6'd9), r_man};
    end

endmodule

// File: rtl/neuron_seq.sv
// neuron_seq: sequential FP16 neuron. Accumulates N handshaked x*w beats onto
// a bias, then applies the activation chosen on the first beat.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              beat handshake
//   in_x, in_w [16]                operand pair
//   in_bias [16], in_mode [2]      sampled on beat 0 only
//   out_valid/out_ready            result handshake
//   out_data [16]                  activated result, held until taken
//
// state | meaning
// S_ACC | accepting beats, accumulating
// S_ACT | last beat taken, activation registered into out_data
// S_OUT | result offered downstream
module neuron_seq
    import neuron_pkg::*;
#(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_w,
    input  logic [15:0] in_bias,
    input  logic [1:0]  in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      acc, mac_a, mac_y, act_y;
    act_mode_t        mode;
    logic             beat, last_beat;

    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (cnt == CNT_LAST);
    assign mac_a     = (cnt == '0) ? in_bias : acc;

    fp16_mac u_mac (
        .a (mac_a),
        .x (in_x),
        .w (in_w),
        .y (mac_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid && cnt == CNT_LAST) state_nxt = S_ACT;
            end
            S_ACT: state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_ACC;
            end
            default: state_nxt = S_ACC;
        endcase
    end

    always_comb begin
        act_y = acc;
        unique case (mode)
            ACT_ID: act_y = acc;
            ACT_RELU: begin
                if (acc[15]) act_y = FP16_ZERO;
            end
            ACT_RELU6: begin
                // Positive FP16 bit patterns order the same as their values.
                if (acc[15])              act_y = FP16_ZERO;
                else if (acc > FP16_SIX)  act_y = FP16_SIX;
            end
            ACT_LEAKY: begin
                // Slope 1/8 is an exponent decrement of 3.
                if (acc[15])
                    act_y = (acc[14:10] <= 5'd3) ? FP16_ZERO
                                                 : {1'b1, 5'(acc[14:10] - 5'd3), acc[9:0]};
            end
            default: act_y = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= FP16_ZERO;
            mode     <= ACT_ID;
            out_data <= FP16_ZERO;
        end else begin
            if (beat) begin
                acc <= mac_y;
                if (cnt == '0) mode <= act_mode_t'(in_mode);
                cnt <= last_beat ? '0 : cnt + 1'b1;
            end
            if (state == S_ACT) out_data <= act_y;
        end
    end

endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: directed scenarios plus randomized vectors for neuron_seq,
// compared against a real-arithmetic reference model.
module tb_neuron_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x, in_w, in_bias;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] vec_x [N];
    logic [15:0] vec_w [N];

    neuron_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_bias   (in_bias),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp_val(input logic [15:0] h);
        int  e = int'(h[14:10]);
        int  m = int'(h[9:0]);
        real v;
        if (e == 0) return 0.0;
        if (e == 31) begin
            e = 30;
            m = 1023;
        end
        v = (1.0 + m / 1024.0) * pow2(e - 15);
        return h[15] ? -v : v;
    endfunction

    // Truncate an exact real to FP16 (toward zero, flush, saturate).
    function automatic logic [15:0] fp_of(input real v);
        real  mag;
        int   e;
        int   m;
        logic s;
        if (v == 0.0) return 16'h0000;
        s   = (v < 0.0);
        mag = s ? -v : v;
        if (mag < pow2(-14))  return 16'h0000;
        if (mag >= 65536.0)   return {s, 15'h7BFF};
        e = 15;
        while (mag >= pow2(e - 14)) e++;
        while (mag < pow2(e - 15))  e--;
        m = $rtoi((mag / pow2(e - 15) - 1.0) * 1024.0);
        return {s, 5'(e), 10'(m)};
    endfunction

    function automatic logic [15:0] mac_model(input logic [15:0] a, input logic [15:0] x, input logic [15:0] w);
        logic [15:0] p;
        p = fp_of(fp_val(x) * fp_val(w));
        return fp_of(fp_val(a) + fp_val(p));
    endfunction

    function automatic logic [15:0] act_model(input logic [15:0] acc, input logic [1:0] mode);
        case (mode)
            2'b01:   return acc[15] ? 16'h0000 : acc;
            2'b10:   return acc[15] ? 16'h0000 : (fp_val(acc) > 6.0 ? 16'h4600 : acc);
            2'b11:   return acc[15] ? fp_of(fp_val(acc) / 8.0) : acc;
            default: return acc;
        endcase
    endfunction

    function automatic logic [15:0] ref_vector(input logic [15:0] bias, input logic [1:0] mode);
        logic [15:0] acc;
        acc = bias;
        for (int k = 0; k < N; k++) acc = mac_model(acc, vec_x[k], vec_w[k]);
        return act_model(acc, mode);
    endfunction

    function automatic logic [15:0] rand_fp();
        int sel = int'($urandom_range(15, 0));
        case (sel)
            0:       return 16'h0000;
            1:       return {1'($urandom), 5'd0, 10'($urandom)};
            2:       return {1'($urandom), 15'h7C00};
            3:       return {1'($urandom), 15'h7BFF};
            default: return {1'($urandom), 5'($urandom_range(20, 10)), 10'($urandom)};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    // Drives beats 0..nb-1 from vec_x/vec_w; junk on the bus during bubbles.
    task automatic drive_beats(input logic [15:0] bias, input logic [1:0] mode,
                               input int nb, input int max_gap, input string tag);
        int g;
        for (int k = 0; k < nb; k++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_x     = 16'($urandom);
                in_w     = 16'($urandom);
                in_bias  = 16'($urandom);
                in_mode  = 2'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_x     = vec_x[k];
            in_w     = vec_w[k];
            in_bias  = (k == 0) ? bias : 16'($urandom);
            in_mode  = (k == 0) ? mode : 2'($urandom);
            if (k == 0) check_eq({tag, ".in_ready_beat0"}, 16'(in_ready), 16'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vector(input logic [15:0] bias, input logic [1:0] mode, input logic [15:0] exp,
                              input int max_gap, input int hold, input string tag);
        drive_beats(bias, mode, N, max_gap, tag);
        check_eq({tag, ".act_no_valid"}, 16'(out_valid), 16'd0);
        check_eq({tag, ".act_no_ready"}, 16'(in_ready), 16'd0);
        @(posedge clk); #1;
        check_eq({tag, ".out_valid"}, 16'(out_valid), 16'd1);
        check_eq({tag, ".out_data"}, out_data, exp);
        repeat (hold) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_x      = 16'($urandom);
            in_w      = 16'($urandom);
            @(posedge clk); #1;
            check_eq({tag, ".hold_valid"}, 16'(out_valid), 16'd1);
            check_eq({tag, ".hold_data"}, out_data, exp);
            check_eq({tag, ".hold_in_ready"}, 16'(in_ready), 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".done_valid"}, 16'(out_valid), 16'd0);
        check_eq({tag, ".done_in_ready"}, 16'(in_ready), 16'd1);
    endtask

    task automatic load_s1();
        vec_x[0] = 16'h3C00; vec_x[1] = 16'h4000; vec_x[2] = 16'h0000; vec_x[3] = 16'hBC00;
        vec_w[0] = 16'h3800; vec_w[1] = 16'hBC00; vec_w[2] = 16'h4000; vec_w[3] = 16'h3C00;
    endtask

    task automatic load_pair(input logic [15:0] x, input logic [15:0] w);
        for (int k = 0; k < N; k++) begin
            vec_x[k] = x;
            vec_w[k] = w;
        end
    endtask

    initial begin
        logic [15:0] bias_r;
        logic [1:0]  mode_r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_bias   = '0;
        in_mode   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("reset.out_valid", 16'(out_valid), 16'd0);
        check_eq("reset.out_data", out_data, 16'h0000);
        check_eq("reset.in_ready", 16'(in_ready), 16'd1);

        // Scenario 1: -2.0 before activation.
        load_s1();
        run_vector(16'h3800, 2'b10, 16'h0000, 0, 0, "s1_relu6");
        run_vector(16'h3800, 2'b00, 16'hC000, 0, 0, "s1_id");
        run_vector(16'h3800, 2'b11, 16'hB400, 0, 0, "s1_leaky");
        run_vector(16'h3800, 2'b01, 16'h0000, 0, 0, "s1_relu");

        // Scenario 2: sum 8.0.
        vec_x[0] = 16'h4400; vec_x[1] = 16'h4400; vec_x[2] = 16'h0000; vec_x[3] = 16'h0000;
        vec_w[0] = 16'h3C00; vec_w[1] = 16'h3C00; vec_w[2] = 16'h0000; vec_w[3] = 16'h0000;
        run_vector(16'h0000, 2'b10, 16'h4600, 0, 0, "s2_relu6");
        run_vector(16'h0000, 2'b01, 16'h4800, 0, 0, "s2_relu");

        // Backpressure, then a normal vector right after.
        load_s1();
        run_vector(16'h3800, 2'b00, 16'hC000, 0, 5, "bp");
        run_vector(16'h3800, 2'b11, 16'hB400, 0, 0, "bp_next");

        // Bubbles between beats.
        run_vector(16'h3800, 2'b00, 16'hC000, 3, 0, "gap_id");
        run_vector(16'h3800, 2'b11, 16'hB400, 3, 0, "gap_leaky");

        // Reset after two accepted beats.
        drive_beats(16'h3800, 2'b10, 2, 0, "rst_mid");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_mid.out_valid", 16'(out_valid), 16'd0);
        check_eq("rst_mid.in_ready", 16'(in_ready), 16'd1);
        run_vector(16'h3800, 2'b00, 16'hC000, 0, 0, "rst_mid_after");

        // Reset while a result is pending.
        drive_beats(16'h3800, 2'b00, N, 0, "rst_out");
        @(posedge clk); #1;
        check_eq("rst_out.pending", 16'(out_valid), 16'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_out.out_valid", 16'(out_valid), 16'd0);
        check_eq("rst_out.in_ready", 16'(in_ready), 16'd1);

        // Saturation.
        load_pair(16'h7BFF, 16'h4000);
        run_vector(16'h0000, 2'b00, 16'h7BFF, 0, 0, "sat_pos");
        load_pair(16'h7BFF, 16'hC000);
        run_vector(16'h0000, 2'b00, 16'hFBFF, 0, 0, "sat_neg");
        run_vector(16'h0000, 2'b01, 16'h0000, 0, 0, "sat_neg_relu");

        // Randomized vectors against the model.
        for (int v = 0; v < 150; v++) begin
            for (int k = 0; k < N; k++) begin
                vec_x[k] = rand_fp();
                vec_w[k] = rand_fp();
            end
            bias_r = rand_fp();
            mode_r = 2'($urandom);
            run_vector(bias_r, mode_r, ref_vector(bias_r, mode_r),
                       int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
